// File: rtl/axi_lite_cfg_pkg.sv
// Shared constants, state encodings and address decode for the AXI4-Lite
// configuration register block.
package axi_lite_cfg_pkg;

    localparam logic [4:0] REG_ID     = 5'h00;
    localparam logic [4:0] REG_CTRL   = 5'h04;
    localparam logic [4:0] REG_CFG    = 5'h08;
    localparam logic [4:0] REG_STATUS = 5'h0C;
    localparam logic [4:0] REG_ERRCNT = 5'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_SOFT_RST   = 0;
    localparam int CTRL_LB_MASTER  = 1;
    localparam int CTRL_ADDR_SWAP  = 2;
    localparam int CTRL_PAT_GEN    = 3;
    localparam int CTRL_PAT_CHK    = 4;
    localparam int CTRL_EN_DROP    = 5;
    localparam int CTRL_RST_ERROR  = 6;
    localparam int CTRL_RW_W       = 6;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    typedef enum logic [2:0] {
        SEL_ID     = 3'd0,
        SEL_CTRL   = 3'd1,
        SEL_CFG    = 3'd2,
        SEL_STATUS = 3'd3,
        SEL_ERRCNT = 3'd4,
        SEL_NONE   = 3'd7
    } reg_sel_e;

    // Byte offset to register select; addr[1:0] are ignored (word access only).
    function automatic reg_sel_e decode_reg(input logic [4:0] off);
        reg_sel_e sel;
        case ({off[4:2], 2'b00})
            REG_ID:     sel = SEL_ID;
            REG_CTRL:   sel = SEL_CTRL;
            REG_CFG:    sel = SEL_CFG;
            REG_STATUS: sel = SEL_STATUS;
            REG_ERRCNT: sel = SEL_ERRCNT;
            default:    sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/axi_lite_cfg_errcnt.sv
// Packet-checker error tracking: sticky error flag (set beats clear) and a
// saturating 32-bit error counter (clear plus increment yields 1).
module axi_lite_cfg_errcnt
    import axi_lite_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        err_pulse,
    input  logic        sticky_clr,
    input  logic        cnt_clr,
    output logic        sticky_err,
    output logic [31:0] err_count
);

    logic        sticky_err_r;
    logic [31:0] err_count_r;

    // Sticky flag: a new error in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_err_r <= 1'b0;
        end else if (err_pulse) begin
            sticky_err_r <= 1'b1;
        end else if (sticky_clr) begin
            sticky_err_r <= 1'b0;
        end
    end

    // Saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_r <= 32'h0000_0000;
        end else if (cnt_clr) begin
            err_count_r <= err_pulse ? 32'h0000_0001 : 32'h0000_0000;
        end else if (err_pulse && (err_count_r != 32'hFFFF_FFFF)) begin
            err_count_r <= err_count_r + 32'h0000_0001;
        end
    end

    assign sticky_err = sticky_err_r;
    assign err_count  = err_count_r;

endmodule

// File: rtl/axi_lite_cfg_regs.sv
// AXI4-Lite responder exposing example-design control/config registers and
// packet-checker status; independent write and read channel FSMs.
module axi_lite_cfg_regs
    import axi_lite_cfg_pkg::*;
#(
    parameter int          ADDR_W         = 18,
    parameter logic [31:0] ID_VALUE       = 32'h4C45_474F,
    parameter logic [1:0]  LINE_SPEED_RST = 2'b10
)
(
    input  logic              axi_lite_clk,
    input  logic              axi_lite_rst,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              soft_rst,
    output logic              lb_master_slaven,
    output logic              slvlb_addr_swap,
    output logic              pat_gen_enable,
    output logic              pat_chk_enable,
    output logic              pat_chk_en_drop,
    output logic              pat_chk_rst_error,
    output logic [1:0]        line_speed,
    output logic [4:0]        pkt_types,
    input  logic              pkt_err_pulse,
    input  logic              activity
);

    w_state_e w_state_r, w_state_nxt_s;
    logic     aw_held_r, w_held_r, aw_held_nxt_s, w_held_nxt_s;
    reg_sel_e aw_sel_r, wr_sel_s;
    logic [12:0] wdata_r, wr_data_s;
    logic     aw_hs_s, w_hs_s, b_hs_s, wr_commit_s;
    logic     awready_r, wready_r, bvalid_r;
    logic [1:0] bresp_r;

    r_state_e r_state_r, r_state_nxt_s;
    logic     ar_hs_s, r_hs_s, arready_r, rvalid_r;
    logic [1:0]  rresp_r, rd_resp_s;
    logic [31:0] rdata_r, rd_data_s;

    logic [CTRL_RW_W-1:0] ctrl_r;
    logic        rst_error_r;
    logic [1:0]  line_speed_r;
    logic [4:0]  pkt_types_r;
    logic        sticky_clr_s, cnt_clr_s, sticky_err_s;
    logic [31:0] err_count_s;
    logic        unused_s;

    // Write channel: latch AW/W halves independently, commit when both held.
    always_comb begin
        aw_hs_s       = s_axi_awvalid && awready_r;
        w_hs_s        = s_axi_wvalid && wready_r;
        b_hs_s        = bvalid_r && s_axi_bready;
        wr_sel_s      = aw_held_r ? aw_sel_r : decode_reg(s_axi_awaddr[4:0]);
        wr_data_s     = w_held_r ? wdata_r : s_axi_wdata[12:0];
        wr_commit_s   = 1'b0;
        w_state_nxt_s = w_state_r;
        aw_held_nxt_s = aw_held_r || aw_hs_s;
        w_held_nxt_s  = w_held_r || w_hs_s;
        case (w_state_r)
            W_IDLE: begin
                if (aw_held_nxt_s && w_held_nxt_s) begin
                    wr_commit_s   = 1'b1;
                    w_state_nxt_s = W_RESP;
                    aw_held_nxt_s = 1'b0;
                    w_held_nxt_s  = 1'b0;
                end else begin
                    w_state_nxt_s = W_IDLE;
                end
            end
            W_RESP: begin
                if (b_hs_s) begin
                    w_state_nxt_s = W_IDLE;
                end else begin
                    w_state_nxt_s = W_RESP;
                end
            end
            default: begin
                w_state_nxt_s = W_IDLE;
                aw_held_nxt_s = 1'b0;
                w_held_nxt_s  = 1'b0;
            end
        endcase
    end

    // Write channel state, registered handshakes and B response.
    always_ff @(posedge axi_lite_clk) begin
        if (axi_lite_rst) begin
            w_state_r <= W_IDLE;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            aw_sel_r  <= SEL_NONE;
            wdata_r   <= 13'h0000;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            w_state_r <= w_state_nxt_s;
            aw_held_r <= aw_held_nxt_s;
            w_held_r  <= w_held_nxt_s;
            awready_r <= (w_state_nxt_s == W_IDLE) && !aw_held_nxt_s;
            wready_r  <= (w_state_nxt_s == W_IDLE) && !w_held_nxt_s;
            if (aw_hs_s) begin
                aw_sel_r <= decode_reg(s_axi_awaddr[4:0]);
            end
            if (w_hs_s) begin
                wdata_r <= s_axi_wdata[12:0];
            end
            if (wr_commit_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= (wr_sel_s == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
            end else if (b_hs_s) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Control/config registers; the rst_error bit is a single-cycle pulse.
    always_ff @(posedge axi_lite_clk) begin
        if (axi_lite_rst) begin
            ctrl_r       <= 6'h00;
            rst_error_r  <= 1'b0;
            line_speed_r <= LINE_SPEED_RST;
            pkt_types_r  <= 5'h00;
        end else begin
            rst_error_r <= 1'b0;
            if (wr_commit_s) begin
                case (wr_sel_s)
                    SEL_CTRL: begin
                        ctrl_r      <= wr_data_s[CTRL_RW_W-1:0];
                        rst_error_r <= wr_data_s[CTRL_RST_ERROR];
                    end
                    SEL_CFG: begin
                        line_speed_r <= wr_data_s[1:0];
                        pkt_types_r  <= wr_data_s[12:8];
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign sticky_clr_s = wr_commit_s && (wr_sel_s == SEL_STATUS) && wr_data_s[0];
    assign cnt_clr_s    = wr_commit_s && (wr_sel_s == SEL_ERRCNT);

    axi_lite_cfg_errcnt u_errcnt (
        .clk        (axi_lite_clk),
        .rst        (axi_lite_rst),
        .err_pulse  (pkt_err_pulse),
        .sticky_clr (sticky_clr_s),
        .cnt_clr    (cnt_clr_s),
        .sticky_err (sticky_err_s),
        .err_count  (err_count_s)
    );

    // Read mux samples current register state, so a same-cycle write is not seen.
    always_comb begin
        ar_hs_s       = s_axi_arvalid && arready_r;
        r_hs_s        = rvalid_r && s_axi_rready;
        rd_data_s     = 32'h0000_0000;
        rd_resp_s     = RESP_OKAY;
        r_state_nxt_s = r_state_r;
        case (decode_reg(s_axi_araddr[4:0]))
            SEL_ID:     rd_data_s = ID_VALUE;
            SEL_CTRL:   rd_data_s = {26'h0, ctrl_r};
            SEL_CFG:    rd_data_s = {19'h0, pkt_types_r, 6'h00, line_speed_r};
            SEL_STATUS: rd_data_s = {30'h0, activity, sticky_err_s};
            SEL_ERRCNT: rd_data_s = err_count_s;
            default:    rd_resp_s = RESP_SLVERR;
        endcase
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_state_nxt_s = R_DATA;
                end else begin
                    r_state_nxt_s = R_IDLE;
                end
            end
            R_DATA: begin
                if (r_hs_s) begin
                    r_state_nxt_s = R_IDLE;
                end else begin
                    r_state_nxt_s = R_DATA;
                end
            end
            default: r_state_nxt_s = R_IDLE;
        endcase
    end

    // Read channel state and registered R response held until rready.
    always_ff @(posedge axi_lite_clk) begin
        if (axi_lite_rst) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0000_0000;
            rresp_r   <= RESP_OKAY;
        end else begin
            r_state_r <= r_state_nxt_s;
            arready_r <= (r_state_nxt_s == R_IDLE);
            if (ar_hs_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_data_s;
                rresp_r  <= rd_resp_s;
            end else if (r_hs_s) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    assign s_axi_awready     = awready_r;
    assign s_axi_wready      = wready_r;
    assign s_axi_bvalid      = bvalid_r;
    assign s_axi_bresp       = bresp_r;
    assign s_axi_arready     = arready_r;
    assign s_axi_rvalid      = rvalid_r;
    assign s_axi_rdata       = rdata_r;
    assign s_axi_rresp       = rresp_r;
    assign soft_rst          = ctrl_r[CTRL_SOFT_RST];
    assign lb_master_slaven  = ctrl_r[CTRL_LB_MASTER];
    assign slvlb_addr_swap   = ctrl_r[CTRL_ADDR_SWAP];
    assign pat_gen_enable    = ctrl_r[CTRL_PAT_GEN];
    assign pat_chk_enable    = ctrl_r[CTRL_PAT_CHK];
    assign pat_chk_en_drop   = ctrl_r[CTRL_EN_DROP];
    assign pat_chk_rst_error = rst_error_r;
    assign line_speed        = line_speed_r;
    assign pkt_types         = pkt_types_r;

    assign unused_s = ^{s_axi_awaddr[ADDR_W-1:5], s_axi_awaddr[1:0],
                        s_axi_araddr[ADDR_W-1:5], s_axi_araddr[1:0],
                        s_axi_wdata[31:13], wr_data_s[7]};

endmodule
